// File: rtl/simple_mips_ifetch.sv
// simple_mips_ifetch: instruction prefetch stage for the simple_mips core.
//
// Issues in-order word fetches over a req/gnt/rvalid memory handshake,
// buffers returned words together with their PCs in a DEPTH-entry FIFO and
// hands them to decode over inst_valid/inst_ready. A redirect pulse flushes
// the FIFO, restarts fetch at redirect_pc and discards in-flight responses.
//
// Parameters:
//   DEPTH     FIFO entries; also caps buffered + outstanding fetches (pow2, >= 2)
//   RESET_PC  fetch address after reset
//
// Ports:
//   clk, reset                 clock; synchronous active-low reset
//   imem_req/imem_addr         fetch request and word-aligned address
//   imem_gnt                   request accepted this cycle
//   imem_rvalid/imem_rdata     in-order read response
//   redirect/redirect_pc       one-cycle restart pulse and target
//   inst_valid/inst_ready      decode handshake
//   inst/inst_pc               instruction word at FIFO head and its PC
//   perf_starve/perf_flush     saturating counters, present only when
//                              SIMPLE_MIPS_IFETCH_PERF_EN is defined
module simple_mips_ifetch #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0010_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc
`ifdef SIMPLE_MIPS_IFETCH_PERF_EN
    ,
    output logic [31:0] perf_starve,
    output logic [31:0] perf_flush
`endif
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic [31:0]   fetch_pc;
    logic [31:0]   resp_pc;
    logic [CW-1:0] count;
    logic [CW-1:0] pending;
    logic [CW-1:0] drop_cnt;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [31:0]   mem_inst [DEPTH];
    logic [31:0]   mem_pc   [DEPTH];

    logic [CW:0]   in_use;
    logic          grant;
    logic          rsp;
    logic          push;
    logic          pop;

    always_comb begin
        // Credit covers both buffered and outstanding words, so every
        // response is guaranteed a FIFO slot when it arrives.
        in_use     = {1'b0, count} + {1'b0, pending};
        imem_req   = reset & ~redirect & (in_use < (CW+1)'(DEPTH));
        imem_addr  = fetch_pc;
        grant      = imem_req & imem_gnt;
        // A response with nothing outstanding is a protocol error; ignore it.
        rsp        = imem_rvalid & (pending != '0);
        push       = rsp & ~redirect & (drop_cnt == '0);
        inst_valid = (count != '0) & ~redirect;
        pop        = inst_valid & inst_ready;
        inst       = mem_inst[rd_ptr];
        inst_pc    = mem_pc[rd_ptr];
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            fetch_pc <= RESET_PC;
            resp_pc  <= RESET_PC;
            count    <= '0;
            pending  <= '0;
            drop_cnt <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_inst[i] <= '0;
                mem_pc[i]   <= '0;
            end
        end else begin
            pending <= pending + CW'(grant) - CW'(rsp);
            if (redirect) begin
                fetch_pc <= {redirect_pc[31:2], 2'b00};
                resp_pc  <= {redirect_pc[31:2], 2'b00};
                // Everything still outstanding after this cycle belongs to the
                // old stream; this already subsumes any earlier drop count.
                drop_cnt <= pending - CW'(rsp);
                count    <= '0;
                wr_ptr   <= '0;
                rd_ptr   <= '0;
            end else begin
                if (grant)
                    fetch_pc <= fetch_pc + 32'd4;
                if (rsp) begin
                    if (drop_cnt != '0)
                        drop_cnt <= drop_cnt - CW'(1);
                    else
                        resp_pc <= resp_pc + 32'd4;
                end
                if (push) begin
                    mem_inst[wr_ptr] <= imem_rdata;
                    mem_pc[wr_ptr]   <= resp_pc;
                    wr_ptr           <= wr_ptr + AW'(1);
                end
                if (pop)
                    rd_ptr <= rd_ptr + AW'(1);
                if (push & ~pop)
                    count <= count + CW'(1);
                else if (pop & ~push)
                    count <= count - CW'(1);
            end
        end
    end

`ifdef SIMPLE_MIPS_IFETCH_PERF_EN
    always_ff @(posedge clk) begin
        if (!reset) begin
            perf_starve <= '0;
            perf_flush  <= '0;
        end else begin
            if (inst_ready & ~inst_valid & (perf_starve != '1))
                perf_starve <= perf_starve + 32'd1;
            if (redirect & (perf_flush != '1))
                perf_flush <= perf_flush + 32'd1;
        end
    end
`endif

    a_rvalid_outstanding: assert property (
        @(posedge clk) disable iff (!reset) imem_rvalid |-> (pending != '0)
    ) else $error("imem_rvalid with no outstanding fetch");

    a_no_overflow: assert property (
        @(posedge clk) disable iff (!reset) push |-> (count < CW'(DEPTH))
    ) else $error("FIFO push while full");

endmodule

// File: tb/tb_simple_mips_ifetch.sv
module tb_simple_mips_ifetch;

    localparam int unsigned DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0010_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
`ifdef SIMPLE_MIPS_IFETCH_PERF_EN
    logic [31:0] perf_starve;
    logic [31:0] perf_flush;
`endif

    always #5 clk = ~clk;

    simple_mips_ifetch #(
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .inst_valid  (inst_valid),
        .inst_ready  (inst_ready),
        .inst        (inst),
        .inst_pc     (inst_pc)
`ifdef SIMPLE_MIPS_IFETCH_PERF_EN
        ,
        .perf_starve (perf_starve),
        .perf_flush  (perf_flush)
`endif
    );

    typedef struct {
        logic [31:0] addr;
        int unsigned epoch;
        int unsigned due;
    } mreq_t;

    typedef struct {
        logic [31:0] word;
        logic [31:0] pc;
    } ent_t;

    typedef struct {
        logic        exp_req;
        logic [31:0] exp_addr;
        logic        exp_valid;
        logic [31:0] exp_pc;
    } vec_t;

    mreq_t       mq[$];
    ent_t        sb[$];
    logic [31:0] pop_log[$];
    int unsigned epoch, cyc, lat, n_grants, n_pops;
    logic [31:0] exp_fetch;
    logic [31:0] m_starve, m_flush;
    logic        s_req, s_valid;
    logic [31:0] s_addr, s_pc;
    int          n_vec, n_err;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hC3A5_5A3C;
    endfunction

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic monitor();
        logic  exp_req, exp_valid;
        ent_t  e;
        mreq_t m;
        s_req   = imem_req;
        s_addr  = imem_addr;
        s_valid = inst_valid;
        s_pc    = inst_pc;
        if (!reset) begin
            check32("req_in_reset", {31'd0, imem_req}, 32'd0);
            mq.delete();
            sb.delete();
            exp_fetch = RESET_PC;
            m_starve  = '0;
            m_flush   = '0;
            return;
        end
`ifdef SIMPLE_MIPS_IFETCH_PERF_EN
        check32("perf_starve", perf_starve, m_starve);
        check32("perf_flush", perf_flush, m_flush);
`endif
        exp_req   = !redirect && ((sb.size() + mq.size()) < DEPTH);
        exp_valid = (sb.size() != 0) && !redirect;
        check32("imem_req", {31'd0, imem_req}, {31'd0, exp_req});
        check32("imem_addr", imem_addr, exp_fetch);
        check32("inst_valid", {31'd0, inst_valid}, {31'd0, exp_valid});
        if (exp_valid && inst_ready && inst_valid) begin
            e = sb.pop_front();
            check32("inst_pc", inst_pc, e.pc);
            check32("inst", inst, e.word);
            n_pops++;
            pop_log.push_back(inst_pc);
        end
        if (inst_ready && !exp_valid)
            m_starve++;
        if (redirect) begin
            epoch++;
            sb.delete();
            exp_fetch = {redirect_pc[31:2], 2'b00};
            m_flush++;
        end
        if (imem_rvalid && mq.size() != 0) begin
            m = mq.pop_front();
            if (m.epoch == epoch)
                sb.push_back('{word: mem_word(m.addr), pc: m.addr});
        end
        if (imem_req && imem_gnt) begin
            mq.push_back('{addr: imem_addr, epoch: epoch, due: cyc + lat});
            exp_fetch = exp_fetch + 32'd4;
            n_grants++;
        end
    endtask

    task automatic drive_mem();
        if (reset && mq.size() != 0 && mq[0].due <= cyc) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mem_word(mq[0].addr);
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = '0;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        monitor();
        @(posedge clk);
        cyc++;
        #1;
        drive_mem();
    endtask

    task automatic drain();
        imem_gnt   = 1'b0;
        inst_ready = 1'b1;
        for (int i = 0; i < 8; i++) tick();
    endtask

    task automatic do_redirect(input logic [31:0] pc);
        redirect    = 1'b1;
        redirect_pc = pc;
        tick();
        redirect    = 1'b0;
    endtask

    vec_t vtab[6];

    initial begin
        reset = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
        redirect = 1'b0; redirect_pc = '0; inst_ready = 1'b0;
        epoch = 0; cyc = 0; lat = 1; n_grants = 0; n_pops = 0;
        exp_fetch = RESET_PC; m_starve = '0; m_flush = '0;
        n_vec = 0; n_err = 0;

        vtab[0] = '{1'b1, 32'h0010_0000, 1'b0, 32'h0};
        vtab[1] = '{1'b1, 32'h0010_0004, 1'b0, 32'h0};
        vtab[2] = '{1'b1, 32'h0010_0008, 1'b1, 32'h0010_0000};
        vtab[3] = '{1'b1, 32'h0010_000C, 1'b1, 32'h0010_0004};
        vtab[4] = '{1'b1, 32'h0010_0010, 1'b1, 32'h0010_0008};
        vtab[5] = '{1'b1, 32'h0010_0014, 1'b1, 32'h0010_000C};

        // reset state
        tick(); tick();
        check32("rst_req", {31'd0, imem_req}, 32'd0);
        check32("rst_addr", imem_addr, RESET_PC);
        check32("rst_valid", {31'd0, inst_valid}, 32'd0);
        check32("rst_inst", inst, 32'd0);
        check32("rst_inst_pc", inst_pc, 32'd0);

        // streaming, 1-cycle memory
        reset = 1'b1; imem_gnt = 1'b1; inst_ready = 1'b1; lat = 1;
        for (int i = 0; i < 6; i++) begin
            tick();
            check32("tab_req", {31'd0, s_req}, {31'd0, vtab[i].exp_req});
            check32("tab_addr", s_addr, vtab[i].exp_addr);
            check32("tab_valid", {31'd0, s_valid}, {31'd0, vtab[i].exp_valid});
            if (vtab[i].exp_valid)
                check32("tab_pc", s_pc, vtab[i].exp_pc);
        end

        // backpressure: credit stops at DEPTH, one pop re-opens it
        drain();
        inst_ready = 1'b0; imem_gnt = 1'b1; n_grants = 0;
        for (int i = 0; i < 8; i++) tick();
        check32("bp_grants", n_grants, DEPTH);
        check32("bp_req_low", {31'd0, s_req}, 32'd0);
        inst_ready = 1'b1; tick();
        inst_ready = 1'b0; tick();
        check32("bp_req_back", {31'd0, s_req}, 32'd1);
        inst_ready = 1'b1;
        for (int i = 0; i < 10; i++) tick();

        // redirect with two slow responses in flight and a buffered word
        drain();
        inst_ready = 1'b0; imem_gnt = 1'b1;
        lat = 1; tick();
        lat = 3; tick(); tick();
        imem_gnt = 1'b0;
        do_redirect(32'h0010_0043);
        check32("redir_valid", {31'd0, s_valid}, 32'd0);
`ifdef SIMPLE_MIPS_IFETCH_PERF_EN
        check32("perf_flush_one", perf_flush, 32'd1);
`endif
        inst_ready = 1'b1; imem_gnt = 1'b1; lat = 1;
        pop_log.delete(); n_pops = 0;
        for (int k = 0; k < 30 && n_pops == 0; k++) tick();
        check32("redir_pop_seen", {31'd0, n_pops != 0}, 32'd1);
        if (pop_log.size() != 0)
            check32("redir_first_pc", pop_log[0], 32'h0010_0040);

        // grant held low: request and address stable
        begin
            logic [31:0] hold;
            for (int i = 0; i < 4; i++) tick();
            imem_gnt = 1'b0;
            hold = exp_fetch;
            for (int i = 0; i < 5; i++) begin
                tick();
                check32("stall_req", {31'd0, s_req}, 32'd1);
                check32("stall_addr", s_addr, hold);
            end
            imem_gnt = 1'b1;
            tick();
            check32("stall_gnt_addr", s_addr, hold);
            tick();
            check32("stall_next_addr", s_addr, hold + 32'd4);
        end

        // back-to-back redirects, last one wraps past 2^32
        drain();
        lat = 3; imem_gnt = 1'b1; tick();
        imem_gnt = 1'b0;
        do_redirect(32'h1234_5678);
        do_redirect(32'hFFFF_FFF8);
        imem_gnt = 1'b1; lat = 1; inst_ready = 1'b1;
        pop_log.delete();
        tick(); check32("wrap_addr0", s_addr, 32'hFFFF_FFF8);
        tick(); check32("wrap_addr1", s_addr, 32'hFFFF_FFFC);
        tick(); check32("wrap_addr2", s_addr, 32'h0000_0000);
        for (int i = 0; i < 8; i++) tick();
        check32("wrap_pops", {31'd0, pop_log.size() >= 3}, 32'd1);
        if (pop_log.size() >= 3) begin
            check32("wrap_pc0", pop_log[0], 32'hFFFF_FFF8);
            check32("wrap_pc1", pop_log[1], 32'hFFFF_FFFC);
            check32("wrap_pc2", pop_log[2], 32'h0000_0000);
        end

        // reset mid-stream with count=3, pending=1
        drain();
        inst_ready = 1'b0; imem_gnt = 1'b1; lat = 1;
        for (int i = 0; i < 4; i++) tick();
        reset = 1'b0; imem_gnt = 1'b0;
        tick();
        reset = 1'b1; imem_gnt = 1'b1; inst_ready = 1'b1;
        tick();
        check32("mrst_valid", {31'd0, s_valid}, 32'd0);
        check32("mrst_addr", s_addr, RESET_PC);
`ifdef SIMPLE_MIPS_IFETCH_PERF_EN
        check32("mrst_perf_flush", perf_flush, 32'd0);
`endif
        pop_log.delete();
        for (int i = 0; i < 10; i++) tick();
        check32("mrst_pops", {31'd0, pop_log.size() != 0}, 32'd1);
        if (pop_log.size() != 0)
            check32("mrst_first_pc", pop_log[0], RESET_PC);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/simple_mips_ifetch.md
Name: simple_mips_ifetch

Overview:
- Instruction prefetch stage sitting directly upstream of the simple_mips decode/execute datapath.
- Issues in-order word reads to instruction memory over a req/gnt/rvalid handshake and buffers returned words with their PCs in a small FIFO.
- Presents instructions to decode over a valid/ready interface.
- Accepts a redirect (taken jump/branch target) that flushes buffered instructions and discards in-flight responses.

Parameters:
- DEPTH, 4: FIFO entries; also the maximum of buffered plus outstanding fetches. Power of two, >= 2.
- RESET_PC, 32'h00100000: fetch address after reset.

Ports:
- clk  input  1  clock; all state on posedge.
- reset  input  1  synchronous, active-low reset.
- imem_req  output  1  fetch request valid.
- imem_addr  output  32  word-aligned fetch address; bits[1:0] always 0.
- imem_gnt  input  1  request accepted this cycle.
- imem_rvalid  input  1  read data valid; responses return in request order.
- imem_rdata  input  32  instruction word.
- redirect  input  1  one-cycle pulse: restart fetch at redirect_pc.
- redirect_pc  input  32  new fetch PC; bits[1:0] ignored.
- inst_valid  output  1  inst/inst_pc valid to decode.
- inst_ready  input  1  decode consumes this cycle.
- inst  output  32  instruction word at FIFO head.
- inst_pc  output  32  PC of inst.

Behaviour:
- Reset (reset==0 at posedge):
  - fetch_pc = resp_pc = RESET_PC.
  - count = pending = drop_cnt = 0.
  - FIFO pointers 0.
  - Outputs: imem_req=0, imem_addr=RESET_PC, inst_valid=0, inst=0, inst_pc=0 (registers cleared).
- Credit rule:
  - imem_req = reset & ~redirect & ((count + pending) < DEPTH).
  - imem_addr = fetch_pc.
  - Address and req hold stable while imem_req & ~imem_gnt.
- Grant (imem_req & imem_gnt):
  - pending += 1.
  - fetch_pc += 4, wrapping modulo 2^32 (0xFFFFFFFC -> 0x00000000).
- Response (imem_rvalid):
  - pending -= 1.
  - If drop_cnt != 0: drop_cnt -= 1, data discarded, resp_pc unchanged.
  - Otherwise: push {imem_rdata, resp_pc} into FIFO, resp_pc += 4 (same wrap).
  - Responses arrive no earlier than the cycle after their grant.
  - imem_rvalid while pending==0 is ignored (simulation assertion fires).
- Output:
  - inst_valid = (count != 0) & ~redirect.
  - inst/inst_pc are the FIFO head, muxed combinationally from storage.
  - Pop on inst_valid & inst_ready.
  - No bypass: with a 1-cycle memory, minimum latency is 2 cycles from grant to inst_valid.
- Simultaneous push and pop: count unchanged. Overflow is impossible by the credit rule; push while full fires an assertion.
- Redirect (cycle with redirect=1):
  - FIFO flushed (count=0, pointers reset).
  - fetch_pc = resp_pc = {redirect_pc[31:2], 2'b00}.
  - drop_cnt = pending - imem_rvalid, i.e. every outstanding response is discarded, including those already marked for dropping.
  - No grant can occur that cycle.
  - Any response arriving in the redirect cycle itself is dropped.
  - Back-to-back redirects: the last one wins; drop_cnt is recomputed each time.
- Reset mid-operation: all state cleared regardless of pending. The memory is reset by the same signal, so no stale responses return.

Optional Feature:
- Macro: SIMPLE_MIPS_IFETCH_PERF_EN.
- Defined: adds outputs perf_starve (32) and perf_flush (32). Both reset to 0, saturate at 0xFFFFFFFF, and update on posedge.
  - perf_starve increments on cycles where inst_ready & ~inst_valid & reset.
  - perf_flush increments on each redirect cycle.
- Undefined: ports and counters absent; all other behaviour identical.

Test Plan:
- Reset, then gnt=1 always, rvalid 1 cycle after grant, inst_ready=1 -> imem_addr 0x00100000, 0x00100004, 0x00100008 on successive cycles; first inst_valid 2 cycles after first grant with inst_pc=0x00100000; pcs increment by 4 with no gaps.
- inst_ready=0 with DEPTH=4 -> exactly 4 grants, then imem_req=0. A single pop re-enables imem_req the following cycle. FIFO order is preserved: inst equals the rdata sequence.
- Responses delayed 3 cycles; redirect with redirect_pc=0x00100043 while pending=2 -> next 2 rvalids discarded; first inst_pc after redirect is 0x00100040; inst_valid=0 in the redirect cycle.
- imem_gnt held low 5 cycles -> imem_req=1 and imem_addr stable throughout; fetch_pc advances only on the granting cycle.
- Redirect to 0xFFFFFFF8 -> addresses 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000; inst_pc follows the same wrap.
- reset low for 1 cycle mid-stream with count=3, pending=1 -> next cycle inst_valid=0, imem_addr=0x00100000, and fetch restarts cleanly. With SIMPLE_MIPS_IFETCH_PERF_EN defined, perf_flush=0 after reset and equals 1 after one redirect.
